// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready pipeline register with 2-entry skid, flush and stall counter
module pipe_stage_elastic #(
  parameter int unsigned       DATA_W   = 160,
  parameter int unsigned       CTRL_W   = 12,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  // Head entry drives the outputs; skid entry absorbs the one extra push that
  // can arrive in the cycle the downstream stalls while o_ready is still high.
  logic              main_v;
  logic [DATA_W-1:0] main_d;
  logic [CTRL_W-1:0] main_c;
  logic              skid_v;
  logic [DATA_W-1:0] skid_d;
  logic [CTRL_W-1:0] skid_c;
  logic [CNT_W-1:0]  stall_cnt;

  logic push;
  logic pop;

  assign o_ready     = !skid_v;
  assign o_valid     = main_v;
  assign push        = i_valid & o_ready;
  assign pop         = main_v & i_ready;
  assign o_data      = main_d;
  // A bubble must never carry side-effecting control bits downstream.
  assign o_ctrl      = main_v ? main_c : '0;
  assign o_occupancy = {1'b0, main_v} + {1'b0, skid_v};
  assign o_stall_cnt = stall_cnt;

  // Head/skid storage: EMPTY -> HEAD -> FULL occupancy walk, flush overrides everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_v <= 1'b0;
      main_d <= NOP_DATA;
      main_c <= '0;
      skid_v <= 1'b0;
      skid_d <= '0;
      skid_c <= '0;
    end else if (i_flush) begin
      main_v <= 1'b0;
      main_d <= NOP_DATA;
      main_c <= '0;
      skid_v <= 1'b0;
    end else if (!main_v) begin
      if (push) begin
        main_v <= 1'b1;
        main_d <= i_data;
        main_c <= i_ctrl;
      end
    end else if (!skid_v) begin
      if (push && pop) begin
        main_d <= i_data;
        main_c <= i_ctrl;
      end else if (push) begin
        skid_v <= 1'b1;
        skid_d <= i_data;
        skid_c <= i_ctrl;
      end else if (pop) begin
        main_v <= 1'b0;
        main_d <= NOP_DATA;
        main_c <= '0;
      end
    end else if (pop) begin
      // FULL: o_ready is low so no push can coincide; skid advances to head.
      main_d <= skid_d;
      main_c <= skid_c;
      skid_v <= 1'b0;
    end
  end

  // Saturating count of stalled cycles; deliberately untouched by flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
    end else if (main_v && !i_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

  localparam int unsigned DW = 160;
  localparam int unsigned CW = 12;
  localparam int unsigned NW = 4;
  localparam logic [DW-1:0] NOP = 160'hA5A5_1234_5678_9ABC_DEF0_0F0F_F0F0_C3C3_3C3C_5A5A;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data = '0;
  logic [CW-1:0] i_ctrl = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_ctrl;
  logic [1:0]    o_occupancy;
  logic [NW-1:0] o_stall_cnt;

  int n_vec = 0;
  int n_bad = 0;
  logic [DW+CW-1:0] exp_q[$];

  pipe_stage_elastic #(
    .DATA_W(DW), .CTRL_W(CW), .NOP_DATA(NOP), .CNT_W(NW)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_ctrl(i_ctrl),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_ctrl(o_ctrl),
    .o_occupancy(o_occupancy), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [DW-1:0] mk(input logic [CW-1:0] c);
    logic [135:0] mid;
    mid = {8'h5C, 116'd0, c};
    return {c, mid, ~c};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; expected response is queued when the push will land.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic rdy, input logic fl);
    i_valid = v;
    i_ctrl  = c;
    i_data  = mk(c);
    i_ready = rdy;
    i_flush = fl;
    @(negedge i_clk);
    if (v && o_ready && !fl) exp_q.push_back({mk(c), c});
    @(posedge i_clk);
    #1;
  endtask

  // Called at posedge+1: reset asserts mid-cycle, outputs checked before any edge.
  task automatic do_reset();
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_ctrl", o_ctrl, 0);
    chk("rst_data", o_data, NOP);
    chk("rst_occ", o_occupancy, 0);
    chk("rst_stall", o_stall_cnt, 0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands an entry downstream.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      chk("skid_implies_head", dut.skid_v & ~dut.main_v, 0);
      if (!o_valid) begin
        chk("bubble_ctrl", o_ctrl, 0);
        chk("bubble_data", o_data, NOP);
      end else if (i_ready && !i_flush) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_out: got ctrl %h expected none", o_ctrl);
        end else begin
          logic [DW+CW-1:0] e;
          e = exp_q.pop_front();
          chk("out_data", o_data, e[DW+CW-1:CW]);
          chk("out_ctrl", o_ctrl, e[CW-1:0]);
        end
      end
      if (i_flush) exp_q.delete();
    end
  end

  initial begin
    int waited;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    chk("init_valid", o_valid, 0);
    chk("init_ready", o_ready, 1);
    chk("init_occ", o_occupancy, 0);

    // streaming at full rate
    step(1, 12'h001, 1, 0);
    chk("str_ctrl1", o_ctrl, 12'h001);
    chk("str_occ1", o_occupancy, 1);
    step(1, 12'h002, 1, 0);
    chk("str_ctrl2", o_ctrl, 12'h002);
    chk("str_occ2", o_occupancy, 1);
    step(1, 12'h003, 1, 0);
    chk("str_ctrl3", o_ctrl, 12'h003);
    chk("str_occ3", o_occupancy, 1);
    step(0, 12'h000, 1, 0);
    chk("str_drained", o_occupancy, 0);
    chk("str_stall", o_stall_cnt, 0);

    // reset while FULL discards everything
    step(1, 12'h007, 0, 0);
    step(1, 12'h008, 0, 0);
    chk("mid_occ", o_occupancy, 2);
    do_reset();

    // backpressure into skid
    step(1, 12'h00A, 0, 0);
    chk("bp_occA", o_occupancy, 1);
    chk("bp_stall0", o_stall_cnt, 0);
    step(1, 12'h00B, 0, 0);
    chk("bp_occ", o_occupancy, 2);
    chk("bp_ready", o_ready, 0);
    chk("bp_head", o_ctrl, 12'h00A);
    chk("bp_stall1", o_stall_cnt, 1);
    for (int i = 0; i < 4; i++) step(0, 12'h000, 0, 0);
    chk("bp_stall5", o_stall_cnt, 5);
    chk("bp_hold_occ", o_occupancy, 2);
    step(0, 12'h000, 1, 0);
    chk("bp_readyback", o_ready, 1);
    chk("bp_headB", o_ctrl, 12'h00B);
    chk("bp_occ1", o_occupancy, 1);
    step(0, 12'h000, 1, 0);
    chk("bp_empty", o_occupancy, 0);

    // flush with simultaneous push and pop while FULL
    step(1, 12'h00C, 0, 0);
    step(1, 12'h00D, 0, 0);
    chk("fl_full", o_occupancy, 2);
    step(1, 12'hFFF, 1, 1);
    chk("fl_valid", o_valid, 0);
    chk("fl_ctrl", o_ctrl, 0);
    chk("fl_occ", o_occupancy, 0);
    chk("fl_data", o_data, NOP);
    chk("fl_ready", o_ready, 1);
    chk("fl_stall_kept", o_stall_cnt, 6);
    for (int i = 0; i < 3; i++) step(0, 12'h000, 1, 0);
    chk("fl_nothing", o_valid, 0);

    // counter saturation
    do_reset();
    step(1, 12'h005, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 12'h000, 0, 0);
    chk("sat_15", o_stall_cnt, 15);
    for (int i = 0; i < 5; i++) step(0, 12'h000, 0, 0);
    chk("sat_hold", o_stall_cnt, 15);
    step(0, 12'h000, 1, 0);
    chk("sat_after_pop", o_stall_cnt, 15);
    chk("sat_empty", o_occupancy, 0);

    // random valid/ready traffic with rare flushes
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      step(($urandom % 4) != 0, CW'($urandom), ($urandom % 3) != 0, ($urandom % 97) == 0);
    end
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      step(0, 12'h000, 1, 0);
      waited++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_occ", o_occupancy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
